// File: rtl/div_ctrl.sv
// div_ctrl: sequences M-extension divides onto an external iterative divider and
// short-circuits divide-by-zero / signed overflow. Define DIV_RESULT_CACHE_EN for a one-entry result cache.
module div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                n_rst_i,
  input  logic                req_valid_i,
  input  logic [1:0]          op_i,
  input  logic [DATA_W-1:0]   rs1_i,
  input  logic [DATA_W-1:0]   rs2_i,
  input  logic [4:0]          rd_addr_i,
  input  logic                flush_i,
  output logic                div_start_o,
  output logic                div_signed_o,
  output logic [DATA_W-1:0]   dividend_o,
  output logic [DATA_W-1:0]   divisor_o,
  output logic                div_annul_o,
  input  logic [2*DATA_W-1:0] div_result_i,
  input  logic                div_ready_i,
  output logic                stall_o,
  output logic                wb_valid_o,
  output logic [4:0]          wb_addr_o,
  output logic [DATA_W-1:0]   wb_data_o
);

  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] INT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    REL  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              rem_sel_q, rem_sel_d;
  logic [4:0]        addr_q, addr_d;
  logic              div_signed_q, div_signed_d;
  logic [DATA_W-1:0] dividend_q, dividend_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic              op_signed, op_rem, accept, short_hit;
  logic [DATA_W-1:0] sc_quo, sc_rem;
  logic              cache_hit;
  logic [DATA_W-1:0] cache_quo, cache_rem;

  function automatic logic is_sovf(input logic s, input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
    return s && (a == INT_MIN) && (b == ALL_ONES);
  endfunction

  function automatic logic [DATA_W-1:0] pick(input logic rem, input logic [DATA_W-1:0] q,
                                             input logic [DATA_W-1:0] r);
    return rem ? r : q;
  endfunction

  assign op_signed = ~op_i[0];
  assign op_rem    = op_i[1];
  // wb_valid_q blocks accept so the instruction that just retired is not taken twice.
  assign accept    = (state_q == IDLE) & req_valid_i & ~wb_valid_q & ~flush_i;

`ifdef DIV_RESULT_CACHE_EN
  logic              cache_wr;
  logic              cache_vld_q, cache_vld_d;
  logic              cache_signed_q, cache_signed_d;
  logic [DATA_W-1:0] cache_rs1_q, cache_rs1_d;
  logic [DATA_W-1:0] cache_rs2_q, cache_rs2_d;
  logic [DATA_W-1:0] cache_quo_q, cache_quo_d;
  logic [DATA_W-1:0] cache_rem_q, cache_rem_d;

  assign cache_wr = (state_q == RUN) & div_ready_i & ~flush_i;

  always_comb begin
    cache_vld_d    = cache_vld_q;
    cache_signed_d = cache_signed_q;
    cache_rs1_d    = cache_rs1_q;
    cache_rs2_d    = cache_rs2_q;
    cache_quo_d    = cache_quo_q;
    cache_rem_d    = cache_rem_q;
    if (cache_wr) begin
      cache_vld_d    = 1'b1;
      cache_signed_d = div_signed_q;
      cache_rs1_d    = dividend_q;
      cache_rs2_d    = divisor_q;
      cache_quo_d    = div_result_i[DATA_W-1:0];
      cache_rem_d    = div_result_i[2*DATA_W-1:DATA_W];
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      cache_vld_q    <= 1'b0;
      cache_signed_q <= 1'b0;
      cache_rs1_q    <= '0;
      cache_rs2_q    <= '0;
      cache_quo_q    <= '0;
      cache_rem_q    <= '0;
    end else begin
      cache_vld_q    <= cache_vld_d;
      cache_signed_q <= cache_signed_d;
      cache_rs1_q    <= cache_rs1_d;
      cache_rs2_q    <= cache_rs2_d;
      cache_quo_q    <= cache_quo_d;
      cache_rem_q    <= cache_rem_d;
    end
  end

  assign cache_hit = cache_vld_q & (cache_signed_q == op_signed) &
                     (cache_rs1_q == rs1_i) & (cache_rs2_q == rs2_i);
  assign cache_quo = cache_quo_q;
  assign cache_rem = cache_rem_q;
`else
  assign cache_hit = 1'b0;
  assign cache_quo = '0;
  assign cache_rem = '0;
`endif

  // Results that never need the divider: x/0, INT_MIN/-1 (signed), and cache hits.
  always_comb begin
    short_hit = 1'b1;
    sc_quo    = '0;
    sc_rem    = '0;
    if (rs2_i == '0) begin
      sc_quo = ALL_ONES;
      sc_rem = rs1_i;
    end else if (is_sovf(op_signed, rs1_i, rs2_i)) begin
      sc_quo = INT_MIN;
      sc_rem = '0;
    end else if (cache_hit) begin
      sc_quo = cache_quo;
      sc_rem = cache_rem;
    end else begin
      short_hit = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    rem_sel_d    = rem_sel_q;
    addr_d       = addr_q;
    div_signed_d = div_signed_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    wb_valid_d   = 1'b0;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (short_hit) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = rd_addr_i;
            wb_data_d  = pick(op_rem, sc_quo, sc_rem);
          end else begin
            state_d      = RUN;
            rem_sel_d    = op_rem;
            addr_d       = rd_addr_i;
            div_signed_d = op_signed;
            dividend_d   = rs1_i;
            divisor_d    = rs2_i;
          end
        end
      end
      RUN: begin
        // Flush wins over a same-cycle ready: the result is dropped.
        if (flush_i) begin
          state_d = REL;
        end else if (div_ready_i) begin
          state_d    = REL;
          wb_valid_d = 1'b1;
          wb_addr_d  = addr_q;
          wb_data_d  = pick(rem_sel_q, div_result_i[DATA_W-1:0],
                            div_result_i[2*DATA_W-1:DATA_W]);
        end
      end
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q      <= IDLE;
      rem_sel_q    <= 1'b0;
      addr_q       <= '0;
      div_signed_q <= 1'b0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      rem_sel_q    <= rem_sel_d;
      addr_q       <= addr_d;
      div_signed_q <= div_signed_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign div_start_o  = (state_q == RUN);
  assign div_annul_o  = flush_i & (state_q == RUN);
  assign div_signed_o = div_signed_q;
  assign dividend_o   = dividend_q;
  assign divisor_o    = divisor_q;
  assign stall_o      = req_valid_i & ~wb_valid_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_addr_o    = wb_addr_q;
  assign wb_data_o    = wb_data_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: randomized and directed checks of div_ctrl against an arithmetic reference
// and a variable-latency divider model.
module tb_div_ctrl;

`ifdef DIV_RESULT_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        n_rst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        div_start_o, div_signed_o, div_annul_o;
  logic [31:0] dividend_o, divisor_o;
  logic [63:0] div_result_i = '0;
  logic        div_ready_i = 1'b0;
  logic        stall_o, wb_valid_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;

  int total = 0;
  int bad = 0;
  int div_lat = 0;
  int dcnt = 0;

  bit          cache_v = 1'b0;
  bit          cache_s = 1'b0;
  logic [31:0] cache_a = '0;
  logic [31:0] cache_b = '0;

  div_ctrl dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .req_valid_i(req_valid_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o), .dividend_o(dividend_o),
    .divisor_o(divisor_o), .div_annul_o(div_annul_o), .div_result_i(div_result_i),
    .div_ready_i(div_ready_i), .stall_o(stall_o), .wb_valid_o(wb_valid_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o)
  );

  always #5 clk_i = ~clk_i;

  // RISC-V divide semantics in plain arithmetic; returns {remainder, quotient}.
  function automatic logic [63:0] div_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (s) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m;
    m = div_model(~op[0], a, b);
    return op[1] ? m[63:32] : m[31:0];
  endfunction

  function automatic bit expect_short(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1'b1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    if (CACHE_EN && cache_v && cache_s == !op[0] && cache_a == a && cache_b == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic ref_commit(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (CACHE_EN && !expect_short(op, a, b)) begin
      cache_v = 1'b1; cache_s = !op[0]; cache_a = a; cache_b = b;
    end
  endtask

  // Divider: result becomes valid div_lat cycles after start is first seen, held while start stays high.
  always @(negedge clk_i) begin
    if (!div_start_o) begin
      dcnt = 0;
      div_ready_i = 1'b0;
    end else if (dcnt >= div_lat) begin
      div_ready_i = 1'b1;
      div_result_i = div_model(div_signed_o, dividend_o, divisor_o);
    end else begin
      dcnt = dcnt + 1;
      div_ready_i = 1'b0;
    end
  end

  // Presents one request and observes it until writeback plus tail cycles; no checking here.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int tail, output int cyc, output int starts,
                        output int wbs, output logic [31:0] data, output logic [4:0] addr,
                        output logic stall_acc, output logic stall_wb);
    bit seen;
    seen = 1'b0; cyc = 0; starts = 0; wbs = 0; data = '0; addr = '0; stall_wb = 1'b1;
    req_valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_addr_i = rd;
    #1 stall_acc = stall_o;
    while (!seen && cyc < 300) begin
      @(posedge clk_i); #1;
      cyc++;
      if (div_start_o) starts++;
      if (wb_valid_o) begin
        seen = 1'b1; wbs++; data = wb_data_o; addr = wb_addr_o; stall_wb = stall_o;
        req_valid_i = 1'b0;
      end
    end
    req_valid_i = 1'b0;
    for (int t = 0; t < tail; t++) begin
      @(posedge clk_i); #1;
      if (div_start_o) starts++;
      if (wb_valid_o) wbs++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    total++; if (div_start_o !== 1'b0) begin bad++; $display("FAIL reset start got=%b want=0", div_start_o); end
    total++; if (div_annul_o !== 1'b0) begin bad++; $display("FAIL reset annul got=%b want=0", div_annul_o); end
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL reset wb_valid got=%b want=0", wb_valid_o); end
    total++; if (div_signed_o !== 1'b0) begin bad++; $display("FAIL reset signed got=%b want=0", div_signed_o); end
    total++; if ({dividend_o, divisor_o} !== 64'd0) begin bad++; $display("FAIL reset operands got=%h want=0", {dividend_o, divisor_o}); end
    total++; if ({wb_addr_o, wb_data_o} !== 37'd0) begin bad++; $display("FAIL reset wb got=%h want=0", {wb_addr_o, wb_data_o}); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset stall got=%b want=0", stall_o); end
    @(negedge clk_i); n_rst_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [8];
    logic [31:0] as [8], bs [8], exp [8];
    int          lats [8];
    int cyc, st, wbs;
    logic [31:0] d;
    logic [4:0]  ad;
    logic sa, sw;
    bit sh;
    ops  = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b01};
    as   = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    bs   = '{32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exp  = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0};
    lats = '{4, 3, 2, 0, 0, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      div_lat = lats[i];
      sh = expect_short(ops[i], as[i], bs[i]);
      run_op(ops[i], as[i], bs[i], 5'(i + 1), 2, cyc, st, wbs, d, ad, sa, sw);
      total++; if (d !== exp[i]) begin bad++; $display("FAIL directed%0d data got=%h want=%h", i, d, exp[i]); end
      total++; if (cyc != (sh ? 1 : 2 + lats[i])) begin bad++; $display("FAIL directed%0d latency got=%0d want=%0d", i, cyc, sh ? 1 : 2 + lats[i]); end
      total++; if (st != (sh ? 0 : 1 + lats[i])) begin bad++; $display("FAIL directed%0d start_cycles got=%0d want=%0d", i, st, sh ? 0 : 1 + lats[i]); end
      total++; if (wbs != 1) begin bad++; $display("FAIL directed%0d wb_pulses got=%0d want=1", i, wbs); end
      total++; if (ad !== 5'(i + 1)) begin bad++; $display("FAIL directed%0d addr got=%0d want=%0d", i, ad, i + 1); end
      total++; if ({sa, sw} !== 2'b10) begin bad++; $display("FAIL directed%0d stall got=%b want=10", i, {sa, sw}); end
      ref_commit(ops[i], as[i], bs[i]);
    end
  endtask

  task automatic test_flush();
    int cyc, st, wbs, n;
    logic [31:0] d;
    logic [4:0]  ad;
    logic sa, sw;
    bit sh;
    // Flush ten cycles into RUN, then a back-to-back request presented during REL.
    div_lat = 40; wbs = 0;
    req_valid_i = 1'b1; op_i = 2'b01; rs1_i = 32'd1234; rs2_i = 32'd7; rd_addr_i = 5'd9;
    @(posedge clk_i); #1;
    total++; if ({div_start_o, div_signed_o, dividend_o, divisor_o} !== {1'b1, 1'b0, 32'd1234, 32'd7}) begin
      bad++; $display("FAIL flush run_operands got=%b/%b/%0d/%0d want=1/0/1234/7", div_start_o, div_signed_o, dividend_o, divisor_o); end
    for (int i = 0; i < 9; i++) begin @(posedge clk_i); #1; if (wb_valid_o) wbs++; end
    total++; if (div_annul_o !== 1'b0) begin bad++; $display("FAIL flush annul_idle got=%b want=0", div_annul_o); end
    flush_i = 1'b1; #1;
    total++; if (div_annul_o !== 1'b1) begin bad++; $display("FAIL flush annul got=%b want=1", div_annul_o); end
    @(posedge clk_i); #1;
    flush_i = 1'b0; req_valid_i = 1'b0;
    if (wb_valid_o) wbs++;
    total++; if (div_start_o !== 1'b0) begin bad++; $display("FAIL flush rel_start got=%b want=0", div_start_o); end
    total++; if (wbs != 0) begin bad++; $display("FAIL flush wb_pulses got=%0d want=0", wbs); end
    div_lat = 2;
    sh = expect_short(2'b01, 32'd9, 32'd3);
    run_op(2'b01, 32'd9, 32'd3, 5'd3, 2, cyc, st, wbs, d, ad, sa, sw);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL flush b2b data got=%0d want=3", d); end
    total++; if (cyc != 1 + (sh ? 1 : 4)) begin bad++; $display("FAIL flush b2b latency got=%0d want=%0d", cyc, 1 + (sh ? 1 : 4)); end
    ref_commit(2'b01, 32'd9, 32'd3);
    // Flushed operands must not have been cached.
    sh = expect_short(2'b01, 32'd1234, 32'd7);
    run_op(2'b01, 32'd1234, 32'd7, 5'd4, 2, cyc, st, wbs, d, ad, sa, sw);
    total++; if (d !== 32'd176 || cyc != (sh ? 1 : 4)) begin bad++; $display("FAIL flush nocache got=%0d/%0d want=176/%0d", d, cyc, sh ? 1 : 4); end
    ref_commit(2'b01, 32'd1234, 32'd7);

    // Flush in the same cycle the divider reports ready.
    div_lat = 3; wbs = 0; n = 0;
    req_valid_i = 1'b1; op_i = 2'b00; rs1_i = 32'hFFFF_FE0C; rs2_i = 32'd5; rd_addr_i = 5'd5;
    @(posedge clk_i); #1;
    total++; if (div_signed_o !== 1'b1) begin bad++; $display("FAIL flush signed got=%b want=1", div_signed_o); end
    while (div_ready_i !== 1'b1 && n < 50) begin @(negedge clk_i); #1; n++; end
    total++; if (n >= 50) begin bad++; $display("FAIL flush ready_timeout got=%0d want<50", n); end
    flush_i = 1'b1; #1;
    total++; if (div_annul_o !== 1'b1) begin bad++; $display("FAIL flush annul_ready got=%b want=1", div_annul_o); end
    @(posedge clk_i); #1;
    flush_i = 1'b0; req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin if (wb_valid_o || div_start_o) wbs++; @(posedge clk_i); #1; end
    total++; if (wbs != 0) begin bad++; $display("FAIL flush ready_wb got=%0d want=0", wbs); end

    // Flush in IDLE blocks acceptance.
    wbs = 0; st = 0;
    req_valid_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; rs1_i = 32'd50; rs2_i = 32'd0; rd_addr_i = 5'd6;
    for (int i = 0; i < 3; i++) begin @(posedge clk_i); #1; if (wb_valid_o) wbs++; if (div_start_o) st++; end
    total++; if ({wbs, st} != {32'd0, 32'd0} || stall_o !== 1'b1) begin bad++; $display("FAIL flush idle got=wb%0d/start%0d/stall%b want=0/0/1", wbs, st, stall_o); end
    req_valid_i = 1'b0; flush_i = 1'b0;

    // Flush cannot cancel a writeback that is already registered.
    req_valid_i = 1'b1; op_i = 2'b00; rs1_i = 32'd5; rs2_i = 32'd0; rd_addr_i = 5'd7;
    @(posedge clk_i); #1;
    flush_i = 1'b1; #1;
    total++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL flush wb_kept got=%b/%h want=1/ffffffff", wb_valid_o, wb_data_o); end
    req_valid_i = 1'b0; flush_i = 1'b0;
    @(posedge clk_i); #1;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL flush wb_pulse got=%b want=0", wb_valid_o); end
  endtask

  task automatic test_cache();
    int cyc, st, wbs;
    logic [31:0] d;
    logic [4:0]  ad;
    logic sa, sw;
    bit sh;
    div_lat = 5;
    sh = expect_short(2'b00, 32'd1000, 32'd33);
    run_op(2'b00, 32'd1000, 32'd33, 5'd10, 2, cyc, st, wbs, d, ad, sa, sw);
    total++; if (d !== 32'd30 || cyc != (sh ? 1 : 7)) begin bad++; $display("FAIL cache div got=%0d/%0d want=30/%0d", d, cyc, sh ? 1 : 7); end
    ref_commit(2'b00, 32'd1000, 32'd33);
    sh = expect_short(2'b10, 32'd1000, 32'd33);
    run_op(2'b10, 32'd1000, 32'd33, 5'd11, 2, cyc, st, wbs, d, ad, sa, sw);
    total++; if (d !== 32'd10) begin bad++; $display("FAIL cache rem data got=%0d want=10", d); end
    total++; if (cyc != (sh ? 1 : 7) || st != (sh ? 0 : 6)) begin bad++; $display("FAIL cache rem timing got=%0d/%0d want=%0d/%0d", cyc, st, sh ? 1 : 7, sh ? 0 : 6); end
    ref_commit(2'b10, 32'd1000, 32'd33);
  endtask

  task automatic test_back_to_back();
    int cyc, st, wbs, lat;
    logic [31:0] d, a, b;
    logic [4:0]  ad;
    logic [1:0]  op;
    logic sa, sw;
    bit sh;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 2; k++) begin
        op = 2'($urandom_range(0, 3));
        a = (i % 3 == 0) ? $urandom_range(0, 500) : $urandom;
        b = (k == 1 && i % 2 == 0) ? 32'd0 : $urandom_range(1, 40);
        lat = $urandom_range(0, 4);
        div_lat = lat;
        sh = expect_short(op, a, b);
        run_op(op, a, b, 5'(i + 20), (k == 0) ? 0 : 2, cyc, st, wbs, d, ad, sa, sw);
        total++; if (d !== ref_result(op, a, b)) begin bad++; $display("FAIL b2b%0d.%0d data got=%h want=%h", i, k, d, ref_result(op, a, b)); end
        total++; if (cyc != k + (sh ? 1 : 2 + lat)) begin bad++; $display("FAIL b2b%0d.%0d latency got=%0d want=%0d", i, k, cyc, k + (sh ? 1 : 2 + lat)); end
        ref_commit(op, a, b);
      end
    end
  endtask

  task automatic test_random();
    int cyc, st, wbs, lat, r;
    logic [31:0] d, a, b;
    logic [4:0]  ad, rd;
    logic [1:0]  op;
    logic sa, sw;
    bit sh;
    a = 32'd77; b = 32'd3;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3: ;
        4: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); a = ~a + 32'd1; end
        5: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); b = ~b + 32'd1; end
        default: begin a = $urandom; b = $urandom; if (b == 32'd0) b = 32'd1; end
      endcase
      op = 2'($urandom_range(0, 3));
      lat = $urandom_range(0, 5);
      rd = 5'($urandom_range(0, 31));
      div_lat = lat;
      sh = expect_short(op, a, b);
      run_op(op, a, b, rd, 2, cyc, st, wbs, d, ad, sa, sw);
      total++; if (d !== ref_result(op, a, b)) begin bad++; $display("FAIL rand%0d op%0d %h/%h data got=%h want=%h", i, op, a, b, d, ref_result(op, a, b)); end
      total++; if (cyc != (sh ? 1 : 2 + lat) || st != (sh ? 0 : 1 + lat)) begin bad++; $display("FAIL rand%0d timing got=%0d/%0d want=%0d/%0d", i, cyc, st, sh ? 1 : 2 + lat, sh ? 0 : 1 + lat); end
      total++; if (wbs != 1 || ad !== rd) begin bad++; $display("FAIL rand%0d wb got=%0d/%0d want=1/%0d", i, wbs, ad, rd); end
      ref_commit(op, a, b);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, st, wbs;
    logic [31:0] d;
    logic [4:0]  ad;
    logic sa, sw;
    bit sh;
    div_lat = 1;
    run_op(2'b01, 32'd777, 32'd5, 5'd12, 2, cyc, st, wbs, d, ad, sa, sw);
    ref_commit(2'b01, 32'd777, 32'd5);
    div_lat = 20;
    req_valid_i = 1'b1; op_i = 2'b00; rs1_i = 32'd999; rs2_i = 32'd4; rd_addr_i = 5'd13;
    repeat (5) begin @(posedge clk_i); #1; end
    #2 n_rst_i = 1'b0; req_valid_i = 1'b0;
    #1;
    total++; if ({div_start_o, div_annul_o, div_signed_o, wb_valid_o, stall_o} !== 5'b0) begin
      bad++; $display("FAIL midreset ctrl got=%b want=00000", {div_start_o, div_annul_o, div_signed_o, wb_valid_o, stall_o}); end
    total++; if ({dividend_o, divisor_o, wb_data_o, wb_addr_o} !== 101'd0) begin
      bad++; $display("FAIL midreset data got=%h/%h/%h/%h want=0", dividend_o, divisor_o, wb_data_o, wb_addr_o); end
    cache_v = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); n_rst_i = 1'b1;
    @(posedge clk_i); #1;
    wbs = 0; st = 0;
    for (int i = 0; i < 25; i++) begin @(posedge clk_i); #1; if (wb_valid_o) wbs++; if (div_start_o) st++; end
    total++; if (wbs != 0 || st != 0) begin bad++; $display("FAIL midreset after got=wb%0d/start%0d want=0/0", wbs, st); end
    div_lat = 1;
    sh = expect_short(2'b01, 32'd777, 32'd5);
    run_op(2'b01, 32'd777, 32'd5, 5'd14, 2, cyc, st, wbs, d, ad, sa, sw);
    total++; if (d !== 32'd155 || cyc != (sh ? 1 : 3)) begin bad++; $display("FAIL midreset cache_clear got=%0d/%0d want=155/%0d", d, cyc, sh ? 1 : 3); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_cache();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
